// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file write controller.
package regfile_ctrl_pkg;

    // Speculation epoch states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPEC = 2'd1,
        END  = 2'd2,
        MISS = 2'd3
    } spec_state_t;

    localparam int DEFAULT_DATABITWIDTH = 16;
    localparam int DEFAULT_REGCOUNT     = 16;

    // True in the single-cycle states that close an epoch (commit or restore).
    function automatic logic epochClosing(input spec_state_t s);
        return (s == END) || (s == MISS);
    endfunction

endpackage

// File: rtl/regfile_addr_decoder.sv
// Register address to one-hot cell enable, gated by a valid qualifier.
module regfile_addr_decoder
#(
    parameter int REGCOUNT        = 16,
    parameter int REGADDRBITWIDTH = $clog2(REGCOUNT)
) (
    input  logic                       valid,
    input  logic [REGADDRBITWIDTH-1:0] addr,
    output logic [REGCOUNT-1:0]        oneHot
);

    // One comparator per cell; all zero when the request is not valid.
    generate
        for (genvar gi = 0; gi < REGCOUNT; gi++) begin : genCell
            assign oneHot[gi] = valid && (addr == REGADDRBITWIDTH'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_write_controller.sv
// Write-side front end of the register file: arbitrates ALU writeback against
// load returns, decodes one-hot cell enables and runs the speculation epoch FSM
// that produces shadow-capture, commit and restore strobes.
module regfile_write_controller
    import regfile_ctrl_pkg::*;
#(
    parameter int DATABITWIDTH    = DEFAULT_DATABITWIDTH,
    parameter int REGCOUNT        = DEFAULT_REGCOUNT,
    parameter int REGADDRBITWIDTH = $clog2(REGCOUNT)
) (
    input  logic                       clk,
    input  logic                       async_rst_n,
    input  logic                       clk_en,
    input  logic                       SpeculateStart,
    input  logic                       SpeculateResolve,
    input  logic                       SpeculateMispredict,
    input  logic                       WB_Valid,
    output logic                       WB_Ready,
    input  logic [REGADDRBITWIDTH-1:0] WB_Addr,
    input  logic [DATABITWIDTH-1:0]    WB_Data,
    input  logic                       Load_Valid,
    input  logic [REGADDRBITWIDTH-1:0] Load_Addr,
    input  logic [DATABITWIDTH-1:0]    Load_Data,
    output logic                       Speculating,
    output logic [REGCOUNT-1:0]        WillBeWritingTo,
    output logic [REGCOUNT-1:0]        WritebackEn,
    output logic [DATABITWIDTH-1:0]    WritebackData,
    output logic [REGCOUNT-1:0]        LoadWriteEn,
    output logic [DATABITWIDTH-1:0]    LoadWriteData,
    output logic                       EndSpeculationPulse,
    output logic [REGCOUNT-1:0]        MispredictPulse,
    output logic                       SpecError
);

    // Epoch FSM and mask of cells written during the open epoch.
    spec_state_t stateReg, stateNext;
    logic        errorEvent;
    logic [REGCOUNT-1:0] specMaskReg, specMaskNext;
    logic [REGCOUNT-1:0] captureNext;
    logic [REGCOUNT-1:0] maskBase;
    logic [REGCOUNT-1:0] touched;

    // One-entry hold for a writeback that lost to a same-address load or hit the restore slot.
    logic                       wbHoldValidReg, wbHoldValidNext;
    logic [REGADDRBITWIDTH-1:0] wbHoldAddrReg, wbHoldAddrNext;
    logic [DATABITWIDTH-1:0]    wbHoldDataReg, wbHoldDataNext;

    // One-entry hold for a load return that cannot issue in its natural slot.
    logic                       ldHoldValidReg, ldHoldValidNext;
    logic [REGADDRBITWIDTH-1:0] ldHoldAddrReg, ldHoldAddrNext;
    logic [DATABITWIDTH-1:0]    ldHoldDataReg, ldHoldDataNext;

    // Candidates for this cycle's issue slot (held entry takes precedence over a new one).
    logic                       wbAccept;
    logic                       wbCandValid, ldCandValid;
    logic [REGADDRBITWIDTH-1:0] wbCandAddr, ldCandAddr;
    logic [DATABITWIDTH-1:0]    wbCandData, ldCandData;
    logic                       wbIssueValid, ldIssueValid;
    logic                       blockIssue;
    logic [REGCOUNT-1:0]        wbOneHot, ldOneHot;

    // Epoch FSM next state; illegal Start/Resolve events only raise the error flag.
    always_comb begin
        stateNext  = stateReg;
        errorEvent = 1'b0;
        case (stateReg)
            IDLE: begin
                if (SpeculateStart) begin
                    stateNext = SPEC;
                end
                if (SpeculateResolve) begin
                    errorEvent = 1'b1;
                end
            end
            SPEC: begin
                if (SpeculateStart) begin
                    errorEvent = 1'b1;
                end
                if (SpeculateResolve) begin
                    stateNext = SpeculateMispredict ? MISS : END;
                end
            end
            default: begin
                stateNext = IDLE;
                if (SpeculateStart || SpeculateResolve) begin
                    errorEvent = 1'b1;
                end
            end
        endcase
    end

    // Issue-slot arbitration between held/new writebacks and held/new load returns.
    always_comb begin
        // The slot landing in the restore cycle must stay empty: cells are busy
        // restoring shadow copies then, so anything bound for it is parked.
        blockIssue = (stateNext == MISS);

        wbAccept    = WB_Valid && WB_Ready;
        wbCandValid = wbHoldValidReg || wbAccept;
        wbCandAddr  = wbHoldValidReg ? wbHoldAddrReg : WB_Addr;
        wbCandData  = wbHoldValidReg ? wbHoldDataReg : WB_Data;

        ldCandValid = ldHoldValidReg || Load_Valid;
        ldCandAddr  = ldHoldValidReg ? ldHoldAddrReg : Load_Addr;
        ldCandData  = ldHoldValidReg ? ldHoldDataReg : Load_Data;

        wbIssueValid    = 1'b0;
        ldIssueValid    = 1'b0;
        wbHoldValidNext = 1'b0;
        wbHoldAddrNext  = wbHoldAddrReg;
        wbHoldDataNext  = wbHoldDataReg;
        ldHoldValidNext = 1'b0;
        ldHoldAddrNext  = ldHoldAddrReg;
        ldHoldDataNext  = ldHoldDataReg;

        if (blockIssue) begin
            // Park both candidates. Load returns are not back-to-back across a
            // mispredict, so a full load hold never meets a new load here.
            wbHoldValidNext = wbCandValid;
            wbHoldAddrNext  = wbCandAddr;
            wbHoldDataNext  = wbCandData;
            ldHoldValidNext = ldCandValid;
            ldHoldAddrNext  = ldCandAddr;
            ldHoldDataNext  = ldCandData;
        end else begin
            ldIssueValid = ldCandValid;
            // A held load goes first; a load arriving alongside it takes its place.
            if (ldHoldValidReg && Load_Valid) begin
                ldHoldValidNext = 1'b1;
                ldHoldAddrNext  = Load_Addr;
                ldHoldDataNext  = Load_Data;
            end
            // Same-address collision: the load wins, the writeback waits one more slot.
            if (wbCandValid && ldCandValid && (wbCandAddr == ldCandAddr)) begin
                wbHoldValidNext = 1'b1;
                wbHoldAddrNext  = wbCandAddr;
                wbHoldDataNext  = wbCandData;
            end else begin
                wbIssueValid = wbCandValid;
            end
        end
    end

    regfile_addr_decoder #(
        .REGCOUNT        (REGCOUNT),
        .REGADDRBITWIDTH (REGADDRBITWIDTH)
    ) wbDecoder (
        .valid  (wbIssueValid),
        .addr   (wbCandAddr),
        .oneHot (wbOneHot)
    );

    regfile_addr_decoder #(
        .REGCOUNT        (REGCOUNT),
        .REGADDRBITWIDTH (REGADDRBITWIDTH)
    ) ldDecoder (
        .valid  (ldIssueValid),
        .addr   (ldCandAddr),
        .oneHot (ldOneHot)
    );

    // Shadow-capture: strobe a cell on its first write of the epoch, then remember it.
    always_comb begin
        // A fresh epoch starts from an empty mask.
        maskBase    = (stateReg == SPEC) ? specMaskReg : '0;
        touched     = wbOneHot | ldOneHot;
        captureNext = '0;
        if (stateNext == SPEC) begin
            captureNext  = touched & ~maskBase;
            specMaskNext = maskBase | touched;
        end else if (epochClosing(stateReg)) begin
            specMaskNext = '0;
        end else begin
            specMaskNext = specMaskReg;
        end
    end

    // State, holds and registered outputs; clk_en low freezes everything.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            stateReg            <= IDLE;
            specMaskReg         <= '0;
            wbHoldValidReg      <= 1'b0;
            wbHoldAddrReg       <= '0;
            wbHoldDataReg       <= '0;
            ldHoldValidReg      <= 1'b0;
            ldHoldAddrReg       <= '0;
            ldHoldDataReg       <= '0;
            WB_Ready            <= 1'b0;
            Speculating         <= 1'b0;
            WillBeWritingTo     <= '0;
            WritebackEn         <= '0;
            WritebackData       <= '0;
            LoadWriteEn         <= '0;
            LoadWriteData       <= '0;
            EndSpeculationPulse <= 1'b0;
            MispredictPulse     <= '0;
            SpecError           <= 1'b0;
        end else if (clk_en) begin
            stateReg            <= stateNext;
            specMaskReg         <= specMaskNext;
            wbHoldValidReg      <= wbHoldValidNext;
            wbHoldAddrReg       <= wbHoldAddrNext;
            wbHoldDataReg       <= wbHoldDataNext;
            ldHoldValidReg      <= ldHoldValidNext;
            ldHoldAddrReg       <= ldHoldAddrNext;
            ldHoldDataReg       <= ldHoldDataNext;
            // Ready mirrors the hold/FSM condition of the cycle it is presented in.
            WB_Ready            <= !wbHoldValidNext && (stateNext != MISS);
            Speculating         <= (stateNext == SPEC);
            WillBeWritingTo     <= captureNext;
            WritebackEn         <= wbOneHot;
            WritebackData       <= wbIssueValid ? wbCandData : '0;
            LoadWriteEn         <= ldOneHot;
            LoadWriteData       <= ldIssueValid ? ldCandData : '0;
            EndSpeculationPulse <= (stateNext == END);
            MispredictPulse     <= (stateNext == MISS) ? specMaskReg : '0;
            SpecError           <= SpecError || errorEvent;
        end
    end

endmodule
